// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage RV32I pipeline: load-use bubbles, EX-stage
// redirects, data-memory waits with a timeout watchdog, and a saturating stall counter.
module pipeline_hazard_ctrl #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        mem_timeout_err,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  state_e      state_q;
  logic [7:0]  wait_cnt_q;
  logic [7:0]  wait_cnt_d;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;
  logic        err_q;

  logic mstall;
  logic lu_haz;
  logic rs1_hit;
  logic rs2_hit;

  // Hazard detection and the wait count the current stalled cycle would produce
  always_comb begin
    mstall  = mem_req & ~mem_ready;
    rs1_hit = id_uses_rs1 & (id_rs1 == ex_rd);
    rs2_hit = id_uses_rs2 & (id_rs2 == ex_rd);
    lu_haz  = ex_mem_read & ex_reg_write & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);
    if (state_q == MEM_WAIT) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end else begin
      wait_cnt_d = 8'd1;
    end
  end

  // Zero-latency enable/flush decode; a memory stall freezes everything
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    if (rst) begin
      pc_en = 1'b0;
    end else begin
      case (state_q)
        RUN, MEM_WAIT: begin
          if (mstall) begin
            pc_en = 1'b0;
          end else if (ex_branch_taken) begin
            // The squashed ID instruction makes any load-use hazard moot
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (lu_haz) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
          end
        end
        default: begin
          pc_en = 1'b0;
        end
      endcase
    end
  end

  // Stall counter saturates instead of wrapping; ERR cycles are not counted
  always_comb begin
    if (!pc_en && (state_q != ERR) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Controller FSM with memory-timeout watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 16'd0;
      err_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      case (state_q)
        RUN, MEM_WAIT: begin
          if (mstall) begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_cnt_d == MEM_TIMEOUT) begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= MEM_WAIT;
            end
          end else begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
          end
        end
        ERR: begin
          state_q <= ERR;
          err_q   <= 1'b1;
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= 8'd0;
        end
      endcase
    end
  end

  assign mem_timeout_err = err_q;
  assign stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controllers (timeout 16 and 4) share stimulus and are
// checked against an abstract cycle model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_reg_write;
  logic       ex_branch_taken, mem_req, mem_ready;

  logic        pc16, ifen16, iffl16, ixen16, ixfl16, xmen16, mwen16, err16;
  logic [15:0] cnt16;
  logic        pc4, ifen4, iffl4, ixen4, ixfl4, xmen4, mwen4, err4;
  logic [15:0] cnt4;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(8'd16)) dut16 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc16), .ifid_en(ifen16), .ifid_flush(iffl16), .idex_en(ixen16),
    .idex_flush(ixfl16), .exmem_en(xmen16), .memwb_en(mwen16),
    .mem_timeout_err(err16), .stall_count(cnt16));

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(8'd4)) dut4 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc4), .ifid_en(ifen4), .ifid_flush(iffl4), .idex_en(ixen4),
    .idex_flush(ixfl4), .exmem_en(xmen4), .memwb_en(mwen4),
    .mem_timeout_err(err4), .stall_count(cnt4));

  // {pc, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, err, count}
  logic [23:0] act16, act4;
  assign act16 = {pc16, ifen16, iffl16, ixen16, ixfl16, xmen16, mwen16, err16, cnt16};
  assign act4  = {pc4, ifen4, iffl4, ixen4, ixfl4, xmen4, mwen4, err4, cnt4};

  typedef struct {
    logic [23:0] e16;
    logic [23:0] e4;
  } exp_t;
  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: consecutive stalled cycles, dead flag, stall total per instance
  int consec[2] = '{0, 0};
  bit dead[2]   = '{1'b0, 1'b0};
  int stalls[2] = '{0, 0};
  int tmo[2]    = '{16, 4};

  task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic mr, input logic rw, input logic bt,
                       input logic req, input logic rdy);
    bit mst, lu;
    logic [7:0] c;
    logic [23:0] e[2];
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_reg_write = rw; ex_branch_taken = bt;
    mem_req = req; mem_ready = rdy;
    mst = req && !rdy;
    lu  = mr && rw && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    for (int k = 0; k < 2; k++) begin
      if (r)            c = {7'b0000000, dead[k]};
      else if (dead[k]) c = 8'b0000_0001;
      else if (mst)     c = 8'b0000_0000;
      else if (bt)      c = 8'b1111_1110;
      else if (lu)      c = 8'b0001_1110;
      else              c = 8'b1101_0110;
      e[k] = {c, 16'(stalls[k])};
      if (r) begin
        consec[k] = 0; dead[k] = 1'b0; stalls[k] = 0;
      end else if (!dead[k]) begin
        if (!c[7] && stalls[k] < 65535) stalls[k] = stalls[k] + 1;
        if (mst) begin
          consec[k] = consec[k] + 1;
          if (consec[k] == tmo[k]) dead[k] = 1'b1;
        end else begin
          consec[k] = 0;
        end
      end
    end
    x.e16 = e[0];
    x.e4  = e[1];
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: compare each presented cycle against the queued expectation
  always @(negedge clk) begin
    exp_t x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      vectors++;
      if (act16 !== x.e16) begin
        miscompares++;
        $display("FAIL dut16 t=%0t got %h expected %h", $time, act16, x.e16);
      end
      if (act4 !== x.e4) begin
        miscompares++;
        $display("FAIL dut4 t=%0t got %h expected %h", $time, act4, x.e4);
      end
    end
  end

  initial begin
    rst = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on rs2, then normal
    drive(0, 1, 5, 1, 1, 5, 1, 1, 0, 0, 0);
    drive(0, 1, 2, 1, 1, 5, 0, 0, 0, 0, 0);
    // No false hazard: rd=0, and unused rs2
    drive(0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
    drive(0, 1, 5, 1, 0, 5, 1, 1, 0, 0, 0);
    // Branch overrides load-use
    drive(0, 1, 5, 1, 1, 5, 1, 1, 1, 0, 0);
    // Memory wait of 3 cycles, release, then normal
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(0, 1, 5, 1, 1, 5, 1, 1, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("memwait_stall_count", cnt16, 16'd3);
    // Timeout on the short-timeout instance
    repeat (6) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(negedge clk); #1;
    chk("timeout_err4", {15'd0, err4}, 16'd1);
    chk("timeout_err16", {15'd0, err16}, 16'd0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("post_reset_err4", {15'd0, err4}, 16'd0);
    chk("post_reset_count4", cnt4, 16'd0);
    // Randomized phases with varying memory readiness
    for (int b = 0; b < 40; b++) begin
      int rdy_pct;
      rdy_pct = (b % 4 == 0) ? 3 : 60;
      for (int i = 0; i < 80; i++) begin
        drive(($urandom_range(0, 199) == 0),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 99) < rdy_pct));
      end
      if (b % 8 == 7) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    // Saturation via a long load-use stream
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 65540; i++) drive(0, 7, 0, 1, 0, 7, 1, 1, 0, 0, 0);
    @(negedge clk); #1;
    chk("saturate16", cnt16, 16'hFFFF);
    chk("saturate4", cnt4, 16'hFFFF);
    @(negedge clk); #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain left %0d expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
